pll_reset_sequencer: RTL and testbench

Reset sequencer sitting beside the system PLL, on the 50 MHz board reference clock. It drives the PLL's active-high reset, watches the PLL `locked` flag, and releases the system reset only after lock has been continuously stable for a programmable interval. It re-sequences on lock loss and retries the PLL a bounded number of times before flagging a fault, so nothing downstream (CPU, SDRAM controller) ever leaves reset on an unlocked clock.

---
 rtl/pll_reset_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives the PLL reset, qualifies lock and
// releases the system reset only after lock is continuously stable.
module pll_reset_sequencer #(
   parameter int unsigned PLL_RST_CYCLES      = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       locked,
   input  logic       retry_req,
   output logic       pll_rst,
   output logic       sys_reset_n,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [7:0] lock_loss_cnt
);

   localparam logic [15:0] RST_LAST    = 16'(PLL_RST_CYCLES - 1);
   localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
   localparam logic [15:0] TMO_LAST    = 16'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic [3:0]  retry_d;
   logic [7:0]  loss_d;
   logic        sync_meta;
   logic        locked_s;
   logic        pll_rst_d;
   logic        sys_reset_n_d;
   logic        ready_d;
   logic        fault_d;

   // Two-flop synchronizer bringing the PLL lock flag into clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         sync_meta <= locked;
         locked_s  <= sync_meta;
      end
   end

   // Next state, shared counter, retry and loss bookkeeping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_cnt;
      loss_d  = lock_loss_cnt;
      unique case (state_q)
         S_PLL_RST: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == RST_LAST) begin
               state_d = S_WAIT_LOCK;
            end
         end
         S_WAIT_LOCK: begin
            cnt_d = cnt_q + 16'd1;
            if (locked_s) begin
               state_d = S_STABLE;
            end else if (cnt_q == TMO_LAST) begin
               if (retry_cnt == RETRY_MAX) begin
                  state_d = S_FAULT;
               end else begin
                  retry_d = retry_cnt + 4'd1;
                  state_d = S_PLL_RST;
               end
            end
         end
         S_STABLE: begin
            cnt_d = cnt_q + 16'd1;
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!locked_s) begin
               if (lock_loss_cnt != 8'hFF) begin
                  loss_d = lock_loss_cnt + 8'd1;
               end
               retry_d = 4'd0;
               state_d = S_WAIT_LOCK;
            end
         end
         S_FAULT: begin
            if (retry_req) begin
               retry_d = 4'd0;
               state_d = S_PLL_RST;
            end
         end
         default: begin
            state_d = S_PLL_RST;
         end
      endcase
      if (state_d != state_q) begin
         cnt_d = 16'd0;
      end
   end

   // Output values for the state being entered, so they register
   // on the same edge as the state change.
   always_comb begin
      pll_rst_d     = 1'b0;
      sys_reset_n_d = 1'b0;
      ready_d       = 1'b0;
      fault_d       = 1'b0;
      unique case (state_d)
         S_PLL_RST: pll_rst_d = 1'b1;
         S_RUN: begin
            sys_reset_n_d = 1'b1;
            ready_d       = 1'b1;
         end
         S_FAULT: begin
            pll_rst_d = 1'b1;
            fault_d   = 1'b1;
         end
         default: begin
            pll_rst_d = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_PLL_RST;
         cnt_q         <= 16'd0;
         retry_cnt     <= 4'd0;
         lock_loss_cnt <= 8'd0;
         pll_rst       <= 1'b1;
         sys_reset_n   <= 1'b0;
         ready         <= 1'b0;
         fault         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retry_cnt     <= retry_d;
         lock_loss_cnt <= loss_d;
         pll_rst       <= pll_rst_d;
         sys_reset_n   <= sys_reset_n_d;
         ready         <= ready_d;
         fault         <= fault_d;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed vector table,
// hand sequences for lock loss/saturation, and randomized model check.
module tb_pll_reset_sequencer;

   localparam int P  = 4;
   localparam int S  = 8;
   localparam int T  = 20;
   localparam int MR = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       locked = 1'b0;
   logic       retry_req = 1'b0;
   logic       pll_rst;
   logic       sys_reset_n;
   logic       ready;
   logic       fault;
   logic [3:0] retry_cnt;
   logic [7:0] lock_loss_cnt;
   logic [15:0] dut_vec;

   int n_checks = 0;
   int n_pass   = 0;

   always #10 clk = ~clk;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES(P),
      .LOCK_STABLE_CYCLES(S),
      .LOCK_TIMEOUT_CYCLES(T),
      .MAX_RETRIES(MR)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .locked(locked),
      .retry_req(retry_req),
      .pll_rst(pll_rst),
      .sys_reset_n(sys_reset_n),
      .ready(ready),
      .fault(fault),
      .retry_cnt(retry_cnt),
      .lock_loss_cnt(lock_loss_cnt)
   );

   assign dut_vec = {pll_rst, sys_reset_n, ready, fault,
                     retry_cnt, lock_loss_cnt};

   task automatic check(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got pll/sys/rdy/flt=%b retry=%0d loss=%0d, required %b retry=%0d loss=%0d",
                    nm, act[15:12], act[11:8], act[7:0],
                    exp[15:12], exp[11:8], exp[7:0]);
   endtask

   // Vector table
   typedef struct {
      bit          rst_n;
      bit          lk;
      bit          rq;
      int          n;
      logic [15:0] exp;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst_n, bit lk, bit rq, int n,
                               bit e_pll, bit e_sys, bit e_rdy, bit e_flt,
                               int e_r, int e_l, string nm);
      vec_t v;
      v.rst_n = rst_n;
      v.lk    = lk;
      v.rq    = rq;
      v.n     = n;
      v.exp   = {e_pll, e_sys, e_rdy, e_flt, 4'(e_r), 8'(e_l)};
      v.nm    = nm;
      return v;
   endfunction

   // Reference model: phases with elapsed-edge ages
   typedef enum int {M_HOLD, M_AWAIT, M_QUAL, M_LIVE, M_DEAD} mp_t;
   mp_t m_phase;
   int  m_age;
   int  m_tries;
   int  m_losses;
   bit  lq[$];

   task automatic model_reset();
      m_phase  = M_HOLD;
      m_age    = 0;
      m_tries  = 0;
      m_losses = 0;
      lq       = '{1'b0, 1'b0};
   endtask

   task automatic model_step();
      bit  ls;
      mp_t nxt;
      ls = lq.pop_front();
      lq.push_back(locked);
      nxt = m_phase;
      case (m_phase)
         M_HOLD:  if (m_age + 1 == P) nxt = M_AWAIT;
         M_AWAIT: begin
            if (ls) nxt = M_QUAL;
            else if (m_age + 1 == T) begin
               if (m_tries == MR) nxt = M_DEAD;
               else begin
                  m_tries++;
                  nxt = M_HOLD;
               end
            end
         end
         M_QUAL: begin
            if (!ls) nxt = M_AWAIT;
            else if (m_age + 1 == S) nxt = M_LIVE;
         end
         M_LIVE: begin
            if (!ls) begin
               m_losses = (m_losses >= 255) ? 255 : m_losses + 1;
               m_tries  = 0;
               nxt      = M_AWAIT;
            end
         end
         M_DEAD: begin
            if (retry_req) begin
               m_tries = 0;
               nxt     = M_HOLD;
            end
         end
         default: nxt = M_HOLD;
      endcase
      if (nxt != m_phase) m_age = 0;
      else m_age++;
      m_phase = nxt;
   endtask

   function automatic logic [15:0] model_vec();
      bit live;
      bit dead;
      live = (m_phase == M_LIVE);
      dead = (m_phase == M_DEAD);
      return {(m_phase == M_HOLD) || dead, live, live, dead,
              4'(m_tries), 8'(m_losses)};
   endfunction

   initial begin
      int seg_left;
      bit seg_val;

      // bring-up
      tbl.push_back(mk(0,1,0, 2, 1,0,0,0, 0,0, "reset_vals"));
      tbl.push_back(mk(1,1,0, 3, 1,0,0,0, 0,0, "bu_e3"));
      tbl.push_back(mk(1,1,0, 1, 0,0,0,0, 0,0, "bu_e4"));
      tbl.push_back(mk(1,1,0, 8, 0,0,0,0, 0,0, "bu_e12"));
      tbl.push_back(mk(1,1,0, 1, 0,1,1,0, 0,0, "bu_e13"));
      // glitch in STABLE
      tbl.push_back(mk(0,1,0, 2, 1,0,0,0, 0,0, "gl_reset"));
      tbl.push_back(mk(1,1,0, 9, 0,0,0,0, 0,0, "gl_e9"));
      tbl.push_back(mk(1,0,0, 1, 0,0,0,0, 0,0, "gl_e10"));
      tbl.push_back(mk(1,1,0, 2, 0,0,0,0, 0,0, "gl_e12"));
      tbl.push_back(mk(1,1,0, 8, 0,0,0,0, 0,0, "gl_e20"));
      tbl.push_back(mk(1,1,0, 1, 0,1,1,0, 0,0, "gl_e21"));
      // retry then success
      tbl.push_back(mk(0,0,0, 2, 1,0,0,0, 0,0, "rt_reset"));
      tbl.push_back(mk(1,0,0,23, 0,0,0,0, 0,0, "rt_e23"));
      tbl.push_back(mk(1,0,0, 1, 1,0,0,0, 1,0, "rt_e24"));
      tbl.push_back(mk(1,0,0, 2, 1,0,0,0, 1,0, "rt_e26"));
      tbl.push_back(mk(1,1,0, 1, 1,0,0,0, 1,0, "rt_e27"));
      tbl.push_back(mk(1,1,0, 1, 0,0,0,0, 1,0, "rt_e28"));
      tbl.push_back(mk(1,1,0, 8, 0,0,0,0, 1,0, "rt_e36"));
      tbl.push_back(mk(1,1,0, 1, 0,1,1,0, 1,0, "rt_e37"));
      // fault and recovery
      tbl.push_back(mk(0,0,0, 2, 1,0,0,0, 0,0, "ft_reset"));
      tbl.push_back(mk(1,0,0,47, 0,0,0,0, 1,0, "ft_e47"));
      tbl.push_back(mk(1,0,0, 1, 1,0,0,0, 2,0, "ft_e48"));
      tbl.push_back(mk(1,0,0,23, 0,0,0,0, 2,0, "ft_e71"));
      tbl.push_back(mk(1,0,0, 1, 1,0,0,1, 2,0, "ft_e72"));
      tbl.push_back(mk(1,1,0, 8, 1,0,0,1, 2,0, "ft_hold"));
      tbl.push_back(mk(1,1,1, 1, 1,0,0,0, 0,0, "ft_retry"));
      tbl.push_back(mk(1,1,0, 3, 1,0,0,0, 0,0, "ft_e84"));
      tbl.push_back(mk(1,1,0, 1, 0,0,0,0, 0,0, "ft_e85"));
      tbl.push_back(mk(1,1,0, 8, 0,0,0,0, 0,0, "ft_e93"));
      tbl.push_back(mk(1,1,0, 1, 0,1,1,0, 0,0, "ft_e94"));
      // retry_req ignored in RUN
      tbl.push_back(mk(1,1,1, 1, 0,1,1,0, 0,0, "rq_run"));
      tbl.push_back(mk(1,1,0, 1, 0,1,1,0, 0,0, "rq_run2"));

      @(negedge clk);
      foreach (tbl[i]) begin
         reset_n   = tbl[i].rst_n;
         locked    = tbl[i].lk;
         retry_req = tbl[i].rq;
         repeat (tbl[i].n) @(posedge clk);
         @(negedge clk);
         check(tbl[i].nm, dut_vec, tbl[i].exp);
      end

      // lock loss in RUN: sys_reset_n falls on the third edge
      locked = 1'b0;
      @(posedge clk);
      @(negedge clk);
      locked = 1'b1;
      check("loss_e1", dut_vec, {4'b0110, 4'd0, 8'd0});
      @(posedge clk);
      @(negedge clk);
      check("loss_e2", dut_vec, {4'b0110, 4'd0, 8'd0});
      @(posedge clk);
      @(negedge clk);
      check("loss_e3", dut_vec, {4'b0000, 4'd0, 8'd1});
      repeat (13) @(posedge clk);
      @(negedge clk);
      check("loss_rerun", dut_vec, {4'b0110, 4'd0, 8'd1});

      // repeated losses up to saturation
      for (int k = 2; k <= 256; k++) begin
         locked = 1'b0;
         @(posedge clk);
         @(negedge clk);
         locked = 1'b1;
         repeat (15) @(posedge clk);
         @(negedge clk);
         check($sformatf("sat_%0d", k), dut_vec,
               {4'b0110, 4'd0, 8'((k > 255) ? 255 : k)});
      end

      // reset asserted mid-STABLE takes effect immediately
      locked = 1'b0;
      @(posedge clk);
      @(negedge clk);
      locked = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("mid_stable", dut_vec, {4'b0000, 4'd0, 8'd255});
      reset_n = 1'b0;
      #1;
      check("async_rst", dut_vec, {4'b1000, 4'd0, 8'd0});

      // randomized run against the reference model
      model_reset();
      seg_left = 0;
      seg_val  = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 3000; c++) begin
         check("rand", dut_vec, model_vec());
         if (seg_left == 0) begin
            seg_val  = ($urandom_range(0, 9) < 7);
            seg_left = seg_val ? $urandom_range(1, 60)
                               : $urandom_range(1, 100);
         end
         seg_left--;
         locked    = seg_val;
         retry_req = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 599) == 0) begin
            reset_n = 1'b0;
            model_reset();
            #1;
            check("rand_async", dut_vec, model_vec());
         end else begin
            reset_n = 1'b1;
         end
         @(posedge clk);
         if (!reset_n) model_reset();
         else model_step();
         @(negedge clk);
      end
      check("rand_end", dut_vec, model_vec());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
